frame_buffer_arbiter: RTL and testbench
=======================================

# frame_buffer_arbiter

Two-port arbiter sharing the single frame-buffer memory port between the image streaming writer (write requester) and the display scanout reader (read requester). Sits between both requesters and the SPRAM memory controller. Serialises one byte transaction at a time, round-robin on contention, and returns completion pulses and read data to the owning port.

## Interface
- ADDR_W, 32, width of all address buses
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_req  in  1  write request; held high until wr_done
- wr_addr  in  ADDR_W  write address; stable while wr_req high
- wr_data  in  8  write byte; stable while wr_req high
- wr_done  out  1  one-cycle pulse: write transaction finished
- rd_req  in  1  read request; held high until rd_done
- rd_addr  in  ADDR_W  read address; stable while rd_req high
- rd_data  out  8  read byte; valid when rd_done is high, held until the next read completes
- rd_done  out  1  one-cycle pulse: read transaction finished
- mem_req  out  1  memory request to the controller
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  8  memory write byte
- mem_rdata  in  8  memory read byte; sampled with mem_ready
- mem_ready  in  1  controller completion, one cycle or longer
- grant_rd  out  1  current or last owner (1 = read port)
- busy  out  1  high in ISSUE, WAIT and RELEASE
- timeout_err  out  1  sticky abort flag; constant 0 without ARB_TIMEOUT_EN

## Operation
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_done=0, rd_done=0, rd_data=0, grant_rd=1, busy=0, timeout_err=0. Internal state: state=IDLE, last_grant=RD.
- States: IDLE → ISSUE → WAIT → RELEASE → IDLE.
- IDLE: sample wr_req and rd_req.
  - One request: grant it.
  - Both requests: grant the port not equal to last_grant. After reset, write wins the first tie.
  - On grant: latch the port's addr/data into mem_addr/mem_wdata; set mem_we (1 for write, 0 for read); set grant_rd; go to ISSUE.
- ISSUE: mem_req<=1; go to WAIT.
- WAIT:
  - Hold mem_req, mem_we, mem_addr and mem_wdata stable.
  - When mem_ready is sampled high: mem_req<=0; for a read, rd_data<=mem_rdata; assert the owner's done for one cycle; last_grant<=owner; go to RELEASE.
- RELEASE: done pulse is visible; go to IDLE. Requesters drop or re-present req in this cycle.
- mem_ready outside WAIT is ignored.
- Back-to-back: a requester keeps req high and presents a new addr/data in the RELEASE cycle. Round-robin still applies if the other port is requesting.
- Reset mid-transaction: all outputs return to reset values at the next edge, and mem_req drops immediately. The pending transaction is lost and no done pulse is issued.

## Timing
- Request latency: req high in IDLE at cycle N → mem_req high at N+2 (ISSUE at N+1 registers it).
- Completion: mem_ready sampled at cycle M → mem_req low and done high at M+1 (RELEASE) → IDLE at M+2.
- Minimum transaction: 4 cycles with mem_ready returned on the first WAIT cycle.
- Done pulses are exactly one cycle wide. wr_done and rd_done are never high together.

## Configuration
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without mem_ready: mem_req<=0, timeout_err<=1 (sticky until reset), the owner's done pulses anyway, and a read sets rd_data<=8'h00. Go to RELEASE.
- Undefined: no counter; WAIT waits indefinitely; timeout_err tied to 0.

## Test plan
- Single write: wr_req, addr 0x10, data 0xA5 → mem_req at +2 with mem_we=1, mem_addr=0x10, mem_wdata=0xA5; mem_ready after 3 cycles → one-cycle wr_done; rd_done stays 0.
- Single read: rd_req, addr 0x20; controller returns mem_rdata=0x3C → rd_done pulse with rd_data=0x3C, held afterwards.
- Contention after reset: wr_req and rd_req both held high for 4 transactions → grant order W, R, W, R; grant_rd=0,1,0,1.
- Ignore stray ready: mem_ready pulsed while IDLE and during ISSUE → no done pulse; the following WAIT completes normally.
- Reset mid-WAIT: assert reset while mem_req=1 → next cycle mem_req=0, busy=0, no done; a new write then completes normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: read with no mem_ready → mem_req drops after 8 WAIT cycles, rd_done pulses with rd_data=0x00, timeout_err=1 and stays set. Without the macro: mem_req stays high for 100+ cycles and timeout_err=0.

Source files
------------

// File: rtl/frame_buffer_arbiter.sv
// Round-robin arbiter sharing one frame-buffer memory port between a writer and a reader.
// Optional WAIT-state abort counter is enabled by defining ARB_TIMEOUT_EN.
module frame_buffer_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_done,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic              grant_rd,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;
    logic              grant_rd_q, grant_rd_d;
    logic              last_rd_q, last_rd_d;
    logic              pick_rd;
    logic              finish;
    logic              abort;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;

    assign abort = (state_q == WAIT) && !mem_ready
                   && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d  = cnt_q;
        terr_d = terr_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (abort) begin
            terr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // On a tie the port that did not win last time gets the grant.
    assign pick_rd = rd_req && (!wr_req || !last_rd_q);
    assign finish  = (state_q == WAIT) && (mem_ready || abort);

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        grant_rd_d  = grant_rd_q;
        last_rd_d   = last_rd_q;
        wr_done_d   = 1'b0;
        rd_done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_req || rd_req) begin
                    grant_rd_d = pick_rd;
                    mem_we_d   = !pick_rd;
                    if (pick_rd) begin
                        mem_addr_d = rd_addr;
                    end else begin
                        mem_addr_d  = wr_addr;
                        mem_wdata_d = wr_data;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_req_d = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (finish) begin
                    mem_req_d = 1'b0;
                    last_rd_d = grant_rd_q;
                    if (grant_rd_q) begin
                        rd_data_d = mem_ready ? mem_rdata : 8'h00;
                        rd_done_d = 1'b1;
                    end else begin
                        wr_done_d = 1'b1;
                    end
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            rd_data_q   <= 8'h00;
            wr_done_q   <= 1'b0;
            rd_done_q   <= 1'b0;
            grant_rd_q  <= 1'b1;
            last_rd_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            wr_done_q   <= wr_done_d;
            rd_done_q   <= rd_done_d;
            grant_rd_q  <= grant_rd_d;
            last_rd_q   <= last_rd_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign wr_done   = wr_done_q;
    assign rd_done   = rd_done_q;
    assign grant_rd  = grant_rd_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_frame_buffer_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_req, rd_req;
    logic [31:0] wr_addr, rd_addr;
    logic [7:0]  wr_data, rd_data;
    logic        wr_done, rd_done;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        grant_rd, busy, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_buffer_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_done(rd_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant_rd(grant_rd), .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, mem_req}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic exp_rd [4];
    int   hi_cnt;
    logic stuck_ok;

    initial begin
        exp_rd = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset = 1'b1; wr_req = 0; rd_req = 0;
        wr_addr = 0; rd_addr = 0; wr_data = 0;
        mem_rdata = 0; mem_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_mem_we", {31'd0, mem_we}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_grant_rd", {31'd0, grant_rd}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rd_data", {24'd0, rd_data}, 0);
        chk("rst_terr", {31'd0, timeout_err}, 0);
        reset = 1'b0;

        // single write, request latency and 3-cycle controller delay
        wr_req = 1; wr_addr = 32'h10; wr_data = 8'hA5;
        @(negedge clk);
        chk("wr_issue_busy", {31'd0, busy}, 1);
        chk("wr_issue_noreq", {31'd0, mem_req}, 0);
        @(negedge clk);
        chk("wr_req_at2", {31'd0, mem_req}, 1);
        chk("wr_we", {31'd0, mem_we}, 1);
        chk("wr_addr", mem_addr, 32'h10);
        chk("wr_wdata", {24'd0, mem_wdata}, 32'hA5);
        chk("wr_grant", {31'd0, grant_rd}, 0);
        repeat (2) @(negedge clk);
        chk("wr_hold", {31'd0, mem_req}, 1);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0; wr_req = 0;
        chk("wr_done", {31'd0, wr_done}, 1);
        chk("wr_rd_done0", {31'd0, rd_done}, 0);
        chk("wr_req_drop", {31'd0, mem_req}, 0);
        @(negedge clk);
        chk("wr_done_1cyc", {31'd0, wr_done}, 0);
        chk("wr_idle", {31'd0, busy}, 0);

        // single read
        rd_req = 1; rd_addr = 32'h20;
        wait_req("rd_req_up");
        chk("rd_we", {31'd0, mem_we}, 0);
        chk("rd_addr", mem_addr, 32'h20);
        chk("rd_grant", {31'd0, grant_rd}, 1);
        mem_rdata = 8'h3C; mem_ready = 1;
        @(negedge clk);
        mem_ready = 0; mem_rdata = 8'hFF; rd_req = 0;
        chk("rd_done", {31'd0, rd_done}, 1);
        chk("rd_data", {24'd0, rd_data}, 32'h3C);
        chk("rd_wr_done0", {31'd0, wr_done}, 0);
        repeat (2) @(negedge clk);
        chk("rd_done_low", {31'd0, rd_done}, 0);
        chk("rd_data_held", {24'd0, rd_data}, 32'h3C);

        // contention after reset: W, R, W, R
        do_reset();
        wr_req = 1; wr_addr = 32'h100; wr_data = 8'h11;
        rd_req = 1; rd_addr = 32'h200;
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("rr%0d_req", i));
            chk($sformatf("rr%0d_grant", i), {31'd0, grant_rd}, {31'd0, exp_rd[i]});
            chk($sformatf("rr%0d_we", i), {31'd0, mem_we}, {31'd0, !exp_rd[i]});
            chk($sformatf("rr%0d_addr", i), mem_addr, exp_rd[i] ? 32'h200 : 32'h100);
            mem_rdata = 8'h40 + 8'(i); mem_ready = 1;
            @(negedge clk);
            mem_ready = 0;
            chk($sformatf("rr%0d_rdone", i), {31'd0, rd_done}, {31'd0, exp_rd[i]});
            chk($sformatf("rr%0d_wdone", i), {31'd0, wr_done}, {31'd0, !exp_rd[i]});
        end
        chk("rr_rdata", {24'd0, rd_data}, 32'h43);
        wr_req = 0; rd_req = 0;
        repeat (2) @(negedge clk);

        // stray ready in IDLE and ISSUE
        mem_ready = 1;
        @(negedge clk);
        chk("stray_idle_busy", {31'd0, busy}, 0);
        chk("stray_idle_wd", {31'd0, wr_done}, 0);
        chk("stray_idle_rd", {31'd0, rd_done}, 0);
        mem_ready = 0; wr_req = 1; wr_addr = 32'h30; wr_data = 8'h77;
        @(negedge clk);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        chk("stray_issue_req", {31'd0, mem_req}, 1);
        chk("stray_issue_wd", {31'd0, wr_done}, 0);
        @(negedge clk);
        chk("stray_wait_req", {31'd0, mem_req}, 1);
        chk("stray_wait_wd", {31'd0, wr_done}, 0);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0; wr_req = 0;
        chk("stray_done", {31'd0, wr_done}, 1);
        repeat (2) @(negedge clk);

        // reset in WAIT
        rd_req = 1; rd_addr = 32'h55;
        wait_req("rst_wait_req");
        reset = 1;
        @(negedge clk);
        reset = 0; rd_req = 0;
        chk("rst_wait_mreq", {31'd0, mem_req}, 0);
        chk("rst_wait_busy", {31'd0, busy}, 0);
        chk("rst_wait_rdone", {31'd0, rd_done}, 0);
        chk("rst_wait_grant", {31'd0, grant_rd}, 1);
        wr_req = 1; wr_addr = 32'h44; wr_data = 8'h5A;
        wait_req("post_rst_req");
        chk("post_rst_grant", {31'd0, grant_rd}, 0);
        chk("post_rst_wdata", {24'd0, mem_wdata}, 32'h5A);
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0; wr_req = 0;
        chk("post_rst_done", {31'd0, wr_done}, 1);
        chk("post_rst_rdone", {31'd0, rd_done}, 0);
        repeat (2) @(negedge clk);

        // read with no controller response
        rd_req = 1; rd_addr = 32'h66;
        wait_req("to_req");
`ifdef ARB_TIMEOUT_EN
        hi_cnt = 0;
        while (mem_req === 1'b1 && hi_cnt < 50) begin
            hi_cnt++;
            @(negedge clk);
        end
        rd_req = 0;
        chk("to_wait_cycles", hi_cnt, 8);
        chk("to_rdone", {31'd0, rd_done}, 1);
        chk("to_rdata", {24'd0, rd_data}, 0);
        chk("to_err", {31'd0, timeout_err}, 1);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", {31'd0, timeout_err}, 1);
`else
        stuck_ok = 1'b1;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || rd_done !== 1'b0) stuck_ok = 1'b0;
        end
        chk("nto_held", {31'd0, stuck_ok}, 1);
        chk("nto_err", {31'd0, timeout_err}, 0);
        mem_rdata = 8'h99; mem_ready = 1;
        @(negedge clk);
        mem_ready = 0; rd_req = 0;
        chk("nto_rdone", {31'd0, rd_done}, 1);
        chk("nto_rdata", {24'd0, rd_data}, 32'h99);
`endif
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
